// File: rtl/alu_issue_if.sv
// Bundle of the issue stage's instruction handshake, ALU drive, write-back and debug signals.
// Handshake: an instruction transfers on a rising clk edge where instr_valid && instr_ready.
interface alu_issue_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [2:0]  alu_op;
  logic [31:0] alu_res;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic [1:0]  dbg_state;

  modport slave (
    input  instr_valid, instr, alu_res, dbg_raddr,
    output instr_ready, alu_in1, alu_in2, alu_op, wb_valid, wb_addr, wb_data,
           illegal, dbg_rdata, dbg_state
  );

  modport master (
    output instr_valid, instr, alu_res, dbg_raddr,
    input  instr_ready, alu_in1, alu_in2, alu_op, wb_valid, wb_addr, wb_data,
           illegal, dbg_rdata, dbg_state
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Non-pipelined decode/issue/write-back stage in front of a combinational ALU:
// IDLE -> DECODE -> EXEC (ALU_LAT cycles) -> WB, with an internal 32x32 register file.
module alu_issue_stage #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_ORI  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_SRL  = 3'b110;
  localparam logic [2:0] OP_SRA  = 3'b111;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic [3:0]  cnt;
  logic [31:0] rf [32];
  logic [4:0]  dest;
  logic [31:0] res_q;
  logic [31:0] in1_q, in2_q;
  logic [2:0]  op_q;

  // FSM strobes
  logic ready, accept, do_decode, illegal_p, exec_done, wb_p;

  // Instruction fields
  logic [5:0]  f_op, f_funct;
  logic [4:0]  f_rs, f_rt, f_rd, f_shamt;
  logic [15:0] f_imm;

  assign f_op    = ir[31:26];
  assign f_rs    = ir[25:21];
  assign f_rt    = ir[20:16];
  assign f_rd    = ir[15:11];
  assign f_shamt = ir[10:6];
  assign f_funct = ir[5:0];
  assign f_imm   = ir[15:0];

  logic [31:0] rs_val, rt_val;
  assign rs_val = rf[f_rs];
  assign rt_val = rf[f_rt];

  logic        dec_legal;
  logic [2:0]  dec_op;
  logic [31:0] dec_in1, dec_in2;
  logic [4:0]  dec_dest;

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = OP_ADD;
    dec_in1   = rs_val;
    dec_in2   = rt_val;
    dec_dest  = f_rd;
    case (f_op)
      6'h00: begin
        case (f_funct)
          6'h20: dec_op = OP_ADD;
          6'h22: dec_op = OP_SUB;
          6'h25: dec_op = OP_OR;
          6'h00, 6'h02, 6'h03: begin
            // Shifts take the value from rt and the amount from shamt.
            dec_op  = (f_funct == 6'h00) ? OP_SLL :
                      (f_funct == 6'h02) ? OP_SRL : OP_SRA;
            dec_in1 = rt_val;
            dec_in2 = {27'b0, f_shamt};
          end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin
        dec_op   = OP_ADDI;
        dec_in2  = {{16{f_imm[15]}}, f_imm};
        dec_dest = f_rt;
      end
      6'h0D: begin
        dec_op   = OP_ORI;
        dec_in2  = {16'b0, f_imm};
        dec_dest = f_rt;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    do_decode = 1'b0;
    illegal_p = 1'b0;
    exec_done = 1'b0;
    wb_p      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) begin
          accept    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          do_decode = 1'b1;
          state_nxt = S_EXEC;
        end else begin
          illegal_p = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        if (cnt == 4'd0) begin
          exec_done = 1'b1;
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        wb_p      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir    <= '0;
      cnt   <= '0;
      dest  <= '0;
      res_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      op_q  <= OP_ADD;
    end else begin
      if (accept) ir <= bus.instr;
      if (do_decode) begin
        op_q  <= dec_op;
        in1_q <= dec_in1;
        in2_q <= dec_in2;
        dest  <= dec_dest;
        cnt   <= LAT_M1;
      end
      if (state == S_EXEC && cnt != 4'd0) cnt <= cnt - 4'd1;
      // The result is captured on the last EXEC edge and held through WB.
      if (exec_done) res_q <= bus.alu_res;
    end
  end

  // r0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_p && dest != 5'd0) begin
      rf[dest] <= res_q;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.alu_in1     = in1_q;
  assign bus.alu_in2     = in2_q;
  assign bus.alu_op      = op_q;
  assign bus.wb_valid    = wb_p;
  assign bus.wb_addr     = wb_p ? dest  : 5'd0;
  assign bus.wb_data     = wb_p ? res_q : 32'd0;
  assign bus.illegal     = illegal_p;
  assign bus.dbg_rdata   = (bus.dbg_raddr == 5'd0) ? 32'd0 : rf[bus.dbg_raddr];
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: one instance at ALU_LAT=1, one at ALU_LAT=3, behind a reference ALU.
module tb_alu_issue_stage;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alu_issue_if bus_a ();
  alu_issue_if bus_b ();

  alu_issue_stage #(.ALU_LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  alu_issue_stage #(.ALU_LAT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      3'b000, 3'b010: return a + b;
      3'b001:         return a - b;
      3'b011, 3'b100: return a | b;
      3'b101:         return a << b[4:0];
      3'b110:         return a >> b[4:0];
      default:        return 32'($signed(a) >>> b[4:0]);
    endcase
  endfunction

  assign bus_a.alu_res = alu_model(bus_a.alu_op, bus_a.alu_in1, bus_a.alu_in2);
  assign bus_b.alu_res = alu_model(bus_b.alu_op, bus_b.alu_in1, bus_b.alu_in2);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Results captured by run_a, cycle numbers relative to the accept edge (cycle 0).
  int          r_wb_cyc, r_ill_cyc, r_rdy_cyc;
  logic [31:0] r_wb_d, r_in1, r_in2;
  logic [4:0]  r_wb_a;
  logic [2:0]  r_op;

  task automatic run_a(input logic [31:0] w);
    int c;
    @(negedge clk);
    c = 0;
    while (!bus_a.instr_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    bus_a.instr_valid = 1'b1;
    bus_a.instr       = w;
    @(negedge clk);
    bus_a.instr_valid = 1'b0;
    c = 1;
    r_wb_cyc = -1; r_ill_cyc = -1; r_rdy_cyc = -1;
    r_wb_d = 'x; r_wb_a = 'x; r_op = 'x; r_in1 = 'x; r_in2 = 'x;
    while (c < 30 && r_rdy_cyc < 0) begin
      if (bus_a.wb_valid) begin
        r_wb_cyc = c; r_wb_d = bus_a.wb_data; r_wb_a = bus_a.wb_addr;
      end
      if (bus_a.illegal) r_ill_cyc = c;
      if (c == 2) begin
        r_op = bus_a.alu_op; r_in1 = bus_a.alu_in1; r_in2 = bus_a.alu_in2;
      end
      if (bus_a.instr_ready) r_rdy_cyc = c;
      if (r_rdy_cyc < 0) begin
        @(negedge clk);
        c++;
      end
    end
  endtask

  task automatic test_reset();
    int nz;
    int c;
    rst_n = 1'b0;
    bus_a.instr_valid = 1'b0; bus_a.instr = '0; bus_a.dbg_raddr = '0;
    bus_b.instr_valid = 1'b0; bus_b.instr = '0; bus_b.dbg_raddr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (bus_a.instr_ready !== 1'b1 || bus_a.alu_in1 !== 32'd0 || bus_a.alu_in2 !== 32'd0 ||
        bus_a.alu_op !== 3'd0 || bus_a.wb_valid !== 1'b0 || bus_a.wb_addr !== 5'd0 ||
        bus_a.wb_data !== 32'd0 || bus_a.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: rdy=%b in1=%h in2=%h op=%b wbv=%b wba=%h wbd=%h ill=%b exp 1/0/0/0/0/0/0/0",
               bus_a.instr_ready, bus_a.alu_in1, bus_a.alu_in2, bus_a.alu_op, bus_a.wb_valid,
               bus_a.wb_addr, bus_a.wb_data, bus_a.illegal);
    end
    run_a(32'h20010005);
    // Start r2 = r1 + 3 and reset in its first EXEC cycle.
    @(negedge clk);
    bus_a.instr_valid = 1'b1; bus_a.instr = 32'h20220003;
    @(negedge clk);
    bus_a.instr_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus_a.dbg_state !== 2'd2 || bus_a.alu_in1 !== 32'd5) begin
      miscompares++;
      $display("FAIL pre_reset_exec: state=%0d in1=%h exp state=2 in1=00000005",
               bus_a.dbg_state, bus_a.alu_in1);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus_a.instr_ready !== 1'b1 || bus_a.alu_in1 !== 32'd0 || bus_a.alu_in2 !== 32'd0 ||
        bus_a.alu_op !== 3'd0 || bus_a.wb_valid !== 1'b0 || bus_a.dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset: rdy=%b in1=%h in2=%h op=%b wbv=%b state=%0d exp 1/0/0/0/0/0",
               bus_a.instr_ready, bus_a.alu_in1, bus_a.alu_in2, bus_a.alu_op,
               bus_a.wb_valid, bus_a.dbg_state);
    end
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      bus_a.dbg_raddr = 5'(i);
      #1;
      if (bus_a.dbg_rdata !== 32'd0) nz++;
    end
    vectors++;
    if (nz !== 0) begin
      miscompares++;
      $display("FAIL reset_rf_clear: nonzero registers=%0d exp 0", nz);
    end
    bus_a.instr_valid = 1'b1; bus_a.instr = 32'h20010005;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus_a.instr_ready !== 1'b0 || bus_a.dbg_state !== 2'd1) begin
      miscompares++;
      $display("FAIL accept_after_reset: rdy=%b state=%0d exp rdy=0 state=1",
               bus_a.instr_ready, bus_a.dbg_state);
    end
    @(negedge clk);
    bus_a.instr_valid = 1'b0;
    c = 0;
    while (!bus_a.instr_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    bus_a.dbg_raddr = 5'd1;
    #1;
    vectors++;
    if (bus_a.dbg_rdata !== 32'd5) begin
      miscompares++;
      $display("FAIL post_reset_r1: got %h exp 00000005", bus_a.dbg_rdata);
    end
  endtask

  task automatic test_immediates();
    logic [31:0] w   [2] = '{32'h20010005, 32'h2002FFFD};
    logic [4:0]  a   [2] = '{5'd1, 5'd2};
    logic [31:0] e   [2] = '{32'h00000005, 32'hFFFFFFFD};
    for (int i = 0; i < 2; i++) begin
      run_a(w[i]);
      bus_a.dbg_raddr = a[i];
      #1;
      vectors++;
      if (r_wb_cyc !== 3 || r_rdy_cyc !== 4 || r_wb_a !== a[i] || r_wb_d !== e[i] ||
          r_op !== 3'b010 || bus_a.dbg_rdata !== e[i]) begin
        miscompares++;
        $display("FAIL addi_%0d: wbcyc=%0d rdycyc=%0d wba=%0d wbd=%h op=%b rf=%h exp 3/4/%0d/%h/010/%h",
                 i, r_wb_cyc, r_rdy_cyc, r_wb_a, r_wb_d, r_op, bus_a.dbg_rdata, a[i], e[i], e[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [31:0] w  [3] = '{32'h00221820, 32'h00222022, 32'h3425F0F0};
    logic [2:0]  op [3] = '{3'b000, 3'b001, 3'b100};
    logic [4:0]  a  [3] = '{5'd3, 5'd4, 5'd5};
    logic [31:0] e  [3] = '{32'h00000002, 32'h00000008, 32'h0000F0F5};
    for (int i = 0; i < 3; i++) begin
      run_a(w[i]);
      bus_a.dbg_raddr = a[i];
      #1;
      vectors++;
      if (r_op !== op[i] || r_wb_cyc !== 3 || r_wb_a !== a[i] || r_wb_d !== e[i] ||
          bus_a.dbg_rdata !== e[i]) begin
        miscompares++;
        $display("FAIL rtype_%0d: op=%b wbcyc=%0d wba=%0d wbd=%h rf=%h exp %b/3/%0d/%h/%h",
                 i, r_op, r_wb_cyc, r_wb_a, r_wb_d, bus_a.dbg_rdata, op[i], a[i], e[i], e[i]);
      end
    end
  endtask

  task automatic test_shift();
    run_a(32'h00013100);
    bus_a.dbg_raddr = 5'd6;
    #1;
    vectors++;
    if (r_op !== 3'b101 || r_in1 !== 32'd5 || r_in2 !== 32'd4 || r_wb_a !== 5'd6 ||
        bus_a.dbg_rdata !== 32'h00000050) begin
      miscompares++;
      $display("FAIL sll: op=%b in1=%h in2=%h wba=%0d r6=%h exp 101/5/4/6/00000050",
               r_op, r_in1, r_in2, r_wb_a, bus_a.dbg_rdata);
    end
  endtask

  task automatic test_r0_illegal();
    logic [31:0] e [7] = '{32'h0, 32'h5, 32'hFFFFFFFD, 32'h2, 32'h8, 32'hF0F5, 32'h50};
    int bad;
    run_a(32'h20200007);
    bus_a.dbg_raddr = 5'd0;
    #1;
    vectors++;
    if (r_wb_cyc !== 3 || r_wb_a !== 5'd0 || r_wb_d !== 32'h0000000C || bus_a.dbg_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL r0_write: wbcyc=%0d wba=%0d wbd=%h r0=%h exp 3/0/0000000C/00000000",
               r_wb_cyc, r_wb_a, r_wb_d, bus_a.dbg_rdata);
    end
    run_a(32'hFC000000);
    vectors++;
    if (r_ill_cyc !== 1 || r_wb_cyc !== -1 || r_rdy_cyc !== 2) begin
      miscompares++;
      $display("FAIL illegal_timing: illcyc=%0d wbcyc=%0d rdycyc=%0d exp 1/-1/2",
               r_ill_cyc, r_wb_cyc, r_rdy_cyc);
    end
    vectors++;
    if (bus_a.alu_op !== 3'b010 || bus_a.alu_in1 !== 32'd5 || bus_a.alu_in2 !== 32'd7) begin
      miscompares++;
      $display("FAIL illegal_alu_hold: op=%b in1=%h in2=%h exp 010/5/7",
               bus_a.alu_op, bus_a.alu_in1, bus_a.alu_in2);
    end
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      bus_a.dbg_raddr = 5'(i);
      #1;
      if (bus_a.dbg_rdata !== e[i]) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL illegal_rf_unchanged: changed registers=%0d exp 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3] = '{32'h20070001, 32'h20080002, 32'h20090003};
    int acc [3];
    int idx, wbn;
    logic take;
    idx = 0; wbn = 0;
    acc = '{-1, -1, -1};
    @(negedge clk);
    bus_a.instr_valid = 1'b1; bus_a.instr = w[0];
    for (int k = 0; k < 24; k++) begin
      if (bus_a.wb_valid) wbn++;
      take = bus_a.instr_valid && bus_a.instr_ready;
      @(negedge clk);
      if (take) begin
        acc[idx] = k;
        idx++;
        if (idx < 3) bus_a.instr = w[idx];
        else         bus_a.instr_valid = 1'b0;
      end
    end
    vectors++;
    if (idx !== 3 || acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4 || wbn !== 3) begin
      miscompares++;
      $display("FAIL b2b_lat1: accepts=%0d at %0d,%0d,%0d wb=%0d exp 3 accepts 4 apart, 3 wb",
               idx, acc[0], acc[1], acc[2], wbn);
    end
    for (int i = 0; i < 3; i++) begin
      bus_a.dbg_raddr = 5'(7 + i);
      #1;
      vectors++;
      if (bus_a.dbg_rdata !== 32'(i + 1)) begin
        miscompares++;
        $display("FAIL b2b_reg_r%0d: got %h exp %h", 7 + i, bus_a.dbg_rdata, 32'(i + 1));
      end
    end
  endtask

  task automatic test_latency3();
    logic [31:0] w [2] = '{32'h2003000A, 32'h00631820};
    logic [31:0] e [2] = '{32'h0000000A, 32'h00000014};
    int acc [2];
    int idx, wbn, last;
    logic [31:0] sampled;
    logic take;
    idx = 0; wbn = 0; last = -100;
    acc = '{-1, -1};
    sampled = 'x;
    @(negedge clk);
    bus_b.instr_valid = 1'b1; bus_b.instr = w[0];
    for (int k = 0; k < 20; k++) begin
      if (k - last == 4) sampled = bus_b.alu_res;
      if (bus_b.wb_valid) begin
        vectors++;
        if (wbn > 1 || k - last !== 5 || bus_b.wb_data !== sampled || bus_b.wb_data !== e[wbn]) begin
          miscompares++;
          $display("FAIL lat3_wb: cyc=%0d wbd=%h sampled=%h exp cyc=5 wbd=%h",
                   k - last, bus_b.wb_data, sampled, (wbn < 2) ? e[wbn] : 32'hx);
        end
        wbn++;
      end
      take = bus_b.instr_valid && bus_b.instr_ready;
      @(negedge clk);
      if (take) begin
        acc[idx] = k;
        last = k;
        idx++;
        if (idx < 2) bus_b.instr = w[idx];
        else         bus_b.instr_valid = 1'b0;
      end
    end
    vectors++;
    if (idx !== 2 || acc[1] - acc[0] !== 6 || wbn !== 2) begin
      miscompares++;
      $display("FAIL b2b_lat3: accepts=%0d at %0d,%0d wb=%0d exp 2 accepts 6 apart, 2 wb",
               idx, acc[0], acc[1], wbn);
    end
    bus_b.dbg_raddr = 5'd3;
    #1;
    vectors++;
    if (bus_b.dbg_rdata !== 32'h00000014) begin
      miscompares++;
      $display("FAIL lat3_r3: got %h exp 00000014", bus_b.dbg_rdata);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_immediates();
    test_rtype();
    test_shift();
    test_r0_illegal();
    test_back_to_back();
    test_latency3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
